// File: rtl/note_detector.sv
`timescale 1ns/1ps
// Measures the period of a square-wave tone, classifies it into C4..C5,
// and confirms the note after STABLE_N consecutive identical classifications.
module note_detector #(
  parameter int MIN_PER  = 181000,
  parameter int MAX_PER  = 402000,
  parameter int STABLE_N = 3,
  parameter int TH_C4    = 361377,
  parameter int TH_D     = 321949,
  parameter int TH_E     = 294857,
  parameter int TH_F     = 270723,
  parameter int TH_G     = 241187,
  parameter int TH_A     = 214875,
  parameter int TH_B     = 196795
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FREQ_IN,
  output logic [3:0]  note,
  output logic        valid,
  output logic        note_change,
  output logic [18:0] period
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [19:0] MIN_W = 20'(MIN_PER);
  localparam logic [19:0] MAX_W = 20'(MAX_PER);
  localparam logic [18:0] MAX_C = 19'(MAX_PER);
  localparam logic [19:0] T1    = 20'(TH_C4);
  localparam logic [19:0] T2    = 20'(TH_D);
  localparam logic [19:0] T3    = 20'(TH_E);
  localparam logic [19:0] T4    = 20'(TH_F);
  localparam logic [19:0] T5    = 20'(TH_G);
  localparam logic [19:0] T6    = 20'(TH_A);
  localparam logic [19:0] T7    = 20'(TH_B);
  localparam logic [2:0]  STN   = 3'(STABLE_N);

  logic        sync1_q, sync2_q, prev_q;
  logic        edge_det;
  logic [0:0]  state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic [2:0]  match_q, match_d;
  logic [3:0]  note_q, note_d;
  logic        valid_q, valid_d;
  logic        chg_q, chg_d;
  logic [18:0] period_q, period_d;
  logic [19:0] meas;
  logic [3:0]  klass;

  assign edge_det = sync2_q & ~prev_q;
  assign meas     = {1'b0, cnt_q} + 20'd1;

  // Thresholds are exclusive: a period equal to a threshold takes the lower code.
  always_comb begin
    klass = 4'd0;
    if (meas < MIN_W || meas > MAX_W) klass = 4'd0;
    else if (meas > T1) klass = 4'd1;
    else if (meas > T2) klass = 4'd2;
    else if (meas > T3) klass = 4'd3;
    else if (meas > T4) klass = 4'd4;
    else if (meas > T5) klass = 4'd5;
    else if (meas > T6) klass = 4'd6;
    else if (meas > T7) klass = 4'd7;
    else klass = 4'd8;
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    note_d   = note_q;
    period_d = period_q;
    if (edge_det)             cnt_d = '0;
    else if (cnt_q == MAX_C)  cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 19'd1;

    case (state_q)
      IDLE: begin
        if (edge_det) state_d = MEASURE;
      end
      default: begin
        // An edge coinciding with saturation wins over the timeout.
        if (edge_det) begin
          period_d = meas[18:0];
          if (klass == cand_q) begin
            match_d = (match_q >= STN) ? STN : match_q + 3'd1;
          end else begin
            cand_d  = klass;
            match_d = 3'd1;
          end
          if (match_d == STN && cand_d != note_q) note_d = cand_d;
        end else if (cnt_q == MAX_C) begin
          state_d  = IDLE;
          note_d   = '0;
          period_d = '0;
          cand_d   = '0;
          match_d  = '0;
        end
      end
    endcase

    chg_d   = (note_d != note_q);
    valid_d = (note_d != 4'd0);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      match_q  <= '0;
      note_q   <= '0;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
      period_q <= '0;
    end else begin
      sync1_q  <= FREQ_IN;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      chg_q    <= chg_d;
      period_q <= period_d;
    end
  end

  assign note        = note_q;
  assign valid       = valid_q;
  assign note_change = chg_q;
  assign period      = period_q;

endmodule

// File: tb/tb_note_detector.sv
`timescale 1ns/1ps
// Directed bench for note_detector with all periods and thresholds scaled by 1/400.
module tb_note_detector;

  localparam int MINP = 453;
  localparam int MAXP = 1005;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FREQ_IN;
  logic [3:0]  note;
  logic        valid;
  logic        note_change;
  logic [18:0] period;

  note_detector #(
    .MIN_PER(MINP), .MAX_PER(MAXP), .STABLE_N(3),
    .TH_C4(903), .TH_D(805), .TH_E(737), .TH_F(677),
    .TH_G(603), .TH_A(537), .TH_B(492)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FREQ_IN(FREQ_IN),
    .note(note), .valid(valid), .note_change(note_change), .period(period)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int gap;
    int exp_per;
    int exp_note;
    bit exp_chg;
  } vec_t;

  vec_t tab[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;

  always @(negedge CLK) if (note_change === 1'b1) pulses++;

  // reps edges of one period; note holds 'from' until the last, which shows 'to'.
  task automatic add(input int gap, input int from, input int to, input int reps);
    vec_t v;
    for (int i = 0; i < reps; i++) begin
      v.gap      = gap;
      v.exp_per  = gap;
      v.exp_note = (i == reps - 1) ? to : from;
      v.exp_chg  = (i == reps - 1) && (to != from);
      tab.push_back(v);
    end
  endtask

  task automatic check(input string nm, input int ep, input int en, input bit ec);
    bit ev;
    ev = (en != 0);
    vectors++;
    if (period !== 19'(ep) || note !== 4'(en) || valid !== ev || note_change !== ec) begin
      miscompares++;
      $display("FAIL %s: got period=%0d note=%0d valid=%0b chg=%0b, want period=%0d note=%0d valid=%0b chg=%0b",
               nm, period, note, valid, note_change, ep, en, ev, ec);
    end
  endtask

  task automatic first_edge();
    FREQ_IN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  // Called 3 cycles after a rise; next rise lands exactly gap cycles after the previous one.
  task automatic do_edge(input int gap);
    repeat (gap / 2 - 3) @(negedge CLK);
    FREQ_IN = 1'b0;
    repeat (gap - gap / 2) @(negedge CLK);
    FREQ_IN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    add(568, 0, 6, 3);
    add(568, 6, 6, 1);
    add(956, 6, 1, 3);
    add(758, 1, 3, 3);
    add(568, 3, 3, 1);
    add(638, 3, 3, 1);
    add(568, 3, 3, 1);
    add(638, 3, 3, 1);
    add(375, 3, 0, 3);
    add(453, 0, 8, 3);
    add(452, 8, 0, 3);
    add(537, 0, 7, 3);
    add(538, 7, 6, 3);
    add(903, 6, 2, 3);
    add(904, 2, 1, 3);
    add(1005, 1, 1, 3);
    add(1006, 1, 0, 3);
    add(478, 0, 8, 3);

    RESET   = 1'b1;
    FREQ_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset", 0, 0, 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    first_edge();
    check("arm", 0, 0, 0);
    foreach (tab[i]) begin
      do_edge(tab[i].gap);
      check($sformatf("vec%0d_p%0d", i, tab[i].gap), tab[i].exp_per, tab[i].exp_note, tab[i].exp_chg);
    end

    FREQ_IN = 1'b0;
    repeat (MAXP) @(negedge CLK);
    check("pre_timeout", 478, 8, 0);
    @(negedge CLK);
    check("timeout", 0, 0, 1);
    @(negedge CLK);
    check("timeout_after", 0, 0, 0);

    repeat (20) @(negedge CLK);
    first_edge();
    check("rearm", 0, 0, 0);
    do_edge(568); check("a_1", 568, 0, 0);
    do_edge(568); check("a_2", 568, 0, 0);
    do_edge(568); check("a_3", 568, 6, 1);

    repeat (568 / 2 - 3) @(negedge CLK);
    FREQ_IN = 1'b0;
    repeat (100) @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check("reset_async", 0, 0, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (50) @(negedge CLK);
    first_edge();
    check("post_reset_arm", 0, 0, 0);
    do_edge(568); check("post_reset_1", 568, 0, 0);
    do_edge(568); check("post_reset_2", 568, 0, 0);
    do_edge(568); check("post_reset_3", 568, 6, 1);
    repeat (5) @(negedge CLK);

    vectors++;
    if (pulses != 15) begin
      miscompares++;
      $display("FAIL pulse_count: got %0d, want 15", pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 Parameter: MIN_PER, 181000, shortest accepted full period in CLK cycles.
REQ-002 Parameter: MAX_PER, 402000, longest accepted full period in CLK cycles; also the silence timeout.
REQ-003 Parameter: STABLE_N, 3, consecutive identical classifications required before `note` updates (range 1-7).
REQ-004 Port: CLK  input  1  system clock, 100 MHz.
REQ-005 Port: RESET  input  1  asynchronous, active-high reset.
REQ-006 Port: FREQ_IN  input  1  asynchronous square-wave tone, the same form as the piano FREQ output.
REQ-007 Port: note  output  4  confirmed note: 0=none, 1=C4, 2=D, 3=E, 4=F, 5=G, 6=A, 7=B, 8=C5.
REQ-008 Port: valid  output  1  high when note != 0.
REQ-009 Port: note_change  output  1  one-cycle pulse on every change of `note`.
REQ-010 Port: period  output  19  last measured period in CLK cycles; 0 when silent.

Function
REQ-011 FREQ_IN SHALL pass through a 2-flop synchronizer; a rising edge is detected on synced=1 with previous synced=0, 3 CLK cycles after the pin edge.
REQ-012 The cycle counter cnt (19 bit) SHALL be cleared to 0 on each detected edge, increment on every other cycle, and saturate at MAX_PER.
REQ-013 The measured period SHALL be cnt+1 in the edge cycle, which is the cycle distance between consecutive detected edges.
REQ-014 The FSM SHALL have states IDLE (no reference edge) and MEASURE.
REQ-015 In IDLE, a detected edge SHALL set the state to MEASURE and clear cnt, with no measurement taken.
REQ-016 In MEASURE, a detected edge SHALL produce a measurement, load `period`, and classify it.
REQ-017 In MEASURE, when cnt==MAX_PER with no edge in that cycle (timeout), the FSM SHALL go to IDLE and, in the next cycle, set note=0, period=0, candidate=0, match=0.
REQ-018 On timeout, note_change SHALL pulse only if note was nonzero.
REQ-019 If an edge occurs in the same cycle as cnt==MAX_PER, the edge SHALL win: the measurement is MAX_PER+1, the state stays MEASURE, and the classification is code 0.
REQ-020 Classification of a measurement P SHALL be:
- P<MIN_PER or P>MAX_PER gives 0.
- Otherwise, using thresholds that fall to the lower code when P equals a threshold:
  - P>361377 gives 1.
  - P>321949 gives 2.
  - P>294857 gives 3.
  - P>270723 gives 4.
  - P>241187 gives 5.
  - P>214875 gives 6.
  - P>196795 gives 7.
  - else 8.
REQ-021 The confirmation filter SHALL work on each classification k as follows:
- If k==candidate, match=min(match+1, STABLE_N).
- Otherwise candidate=k and match=1.
REQ-022 When match reaches STABLE_N and candidate != note, `note` SHALL load candidate one cycle after the qualifying edge, and note_change SHALL pulse in that same cycle.
REQ-023 Confirmed code 0 from out-of-range periods SHALL also update `note` to 0 through the same filter.
REQ-024 `valid` SHALL be registered in the same cycle as `note`.
REQ-025 `note_change` SHALL never be high for 2 consecutive cycles unless `note` changes on both.

Reset
REQ-026 RESET SHALL asynchronously force these values:
- note=0, valid=0, note_change=0, period=0.
- cnt=0, candidate=0, match=0.
- synchronizer flops=0, state=IDLE.
REQ-027 After RESET is released mid-tone, the first detected edge SHALL only arm MEASURE, and the first measurement SHALL come on the second edge.

Verification
REQ-028 A bench SHALL apply a 440 Hz tone (period 227273) from reset; it SHALL see period=227273 after edge 2, and note=6, valid=1, note_change pulse 1 cycle after edge 4 (STABLE_N=3).
REQ-029 A bench SHALL switch a steady C4 (382226) to E (303370); it SHALL see note stay 1 for 2 E measurements, then become 3 after the 3rd, with exactly one note_change pulse.
REQ-030 A bench SHALL remove the tone while note=8; it SHALL see note=0, period=0, valid=0 and one note_change pulse exactly MAX_PER cycles after the last detected edge plus 1.
REQ-031 A bench SHALL apply a period of 150000; it SHALL see period=150000, and note=0 after 3 measurements if it was previously nonzero.
REQ-032 A bench SHALL alternate periods 227273 and 255102 every edge; it SHALL see note never change, since match never exceeds 1.
REQ-033 A bench SHALL assert RESET for 2 cycles during a steady A tone; it SHALL see outputs 0 immediately, and note=6 again after edge 4 following release.
